// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
package mips_pkg;

  localparam int                 INSTR_W   = 32;
  localparam logic [31:0]        PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline stage register: bubble beats load, otherwise holds; 1-cycle latency.
// Hold (ld_i=0, bubble_i=0) is the stall mechanism for the upstream hazard unit.
module ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ld_i,
  input  logic  bubble_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else if (ld_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control, IF/ID register, fetch counter.
// Fetched word lands in IF/ID one clock after PC points at it; stall holds everything, redirect wins.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                halt_req,
  output logic [31:0]         ifid_pc4,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic                ifid_valid,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;

  logic pc_redir, pc_adv, ifid_ld, ifid_bubble, cnt_inc;

  ifid_t ifid_d, ifid_q;

  assign pc_plus4 = pc_q + PC_INC;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!redirect && halt_req) state_d = HALT;
      HALT:    if (redirect) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: stage controls for this cycle
  always_comb begin
    pc_redir    = 1'b0;
    pc_adv      = 1'b0;
    ifid_ld     = 1'b0;
    ifid_bubble = 1'b0;
    cnt_inc     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      BOOT: begin
        ifid_bubble = 1'b1;
      end
      RUN: begin
        if (redirect) begin
          pc_redir    = 1'b1;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          pc_adv  = 1'b1;
          ifid_ld = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      HALT: begin
        halted      = 1'b1;
        ifid_bubble = 1'b1;
        pc_redir    = redirect;
      end
      default: begin
        ifid_bubble = 1'b1;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_redir) begin
      pc_d = align_pc(redirect_pc);
    end else if (pc_adv) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign ifid_d = '{pc4: pc_plus4, instr: imem_data, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (ifid_ld),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  assign imem_addr  = pc_q;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for the main sequence, hand sequence for async reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, halt_req;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_data, ifid_pc4, ifid_instr;
  logic        ifid_valid, halted;
  logic [15:0] fetch_cnt;

  logic [31:0] s_imem_addr, s_imem_data, s_ifid_pc4, s_ifid_instr;
  logic        s_ifid_valid, s_halted;
  logic [1:0]  s_fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000_0000 + i
  assign imem_data   = 32'h1000_0000 + {2'b00, imem_addr[31:2]};
  assign s_imem_data = 32'h1000_0000 + {2'b00, s_imem_addr[31:2]};

  if_stage #(.RESET_VECTOR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  if_stage #(.RESET_VECTOR(32'h0), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .imem_addr(s_imem_addr), .imem_data(s_imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .ifid_pc4(s_ifid_pc4), .ifid_instr(s_ifid_instr), .ifid_valid(s_ifid_valid),
    .halted(s_halted), .fetch_cnt(s_fetch_cnt)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic        halt;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    int          cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic st, input logic rd, input logic hl, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic [31:0] pc4, input logic [31:0] instr,
                              input logic valid, input logic hlt, input int cnt);
    vec_t v;
    v.stall = st; v.redir = rd; v.halt = hl; v.rpc = rpc;
    v.addr = addr; v.pc4 = pc4; v.instr = instr; v.valid = valid; v.halted = hlt; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] pc4,
                         input logic [31:0] instr, input logic valid, input logic hlt, input int cnt);
    int cnt_s;
    cnt_s = (cnt > 3) ? 3 : cnt;
    chk({tag, " imem_addr"},  imem_addr,  addr);
    chk({tag, " ifid_pc4"},   ifid_pc4,   pc4);
    chk({tag, " ifid_instr"}, ifid_instr, instr);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, valid});
    chk({tag, " halted"},     {31'b0, halted},     {31'b0, hlt});
    chk({tag, " fetch_cnt"},  {16'b0, fetch_cnt},  cnt);
    chk({tag, " fetch_cnt_sat2"}, {30'b0, s_fetch_cnt}, cnt_s);
  endtask

  initial begin
    //                st rd hl rpc           addr          pc4           instr         v  h  cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 0);  // BOOT
    vecs[1]  = mk(0, 0, 0, 32'h0,         32'h4,        32'h4,        32'h1000_0000, 1, 0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,         32'h8,        32'h8,        32'h1000_0001, 1, 0, 2);
    vecs[3]  = mk(1, 0, 0, 32'h0,         32'h8,        32'h8,        32'h1000_0001, 1, 0, 2);
    vecs[4]  = mk(1, 0, 0, 32'h0,         32'h8,        32'h8,        32'h1000_0001, 1, 0, 2);
    vecs[5]  = mk(1, 0, 0, 32'h0,         32'h8,        32'h8,        32'h1000_0001, 1, 0, 2);
    vecs[6]  = mk(0, 0, 0, 32'h0,         32'hC,        32'hC,        32'h1000_0002, 1, 0, 3);
    vecs[7]  = mk(0, 0, 0, 32'h0,         32'h10,       32'h10,       32'h1000_0003, 1, 0, 4);
    vecs[8]  = mk(0, 0, 1, 32'h0,         32'h14,       32'h14,       32'h1000_0004, 1, 1, 5);  // halt at PC=16
    vecs[9]  = mk(1, 0, 1, 32'h0,         32'h14,       32'h0,        32'h0,        0, 1, 5);
    vecs[10] = mk(0, 0, 0, 32'h0,         32'h14,       32'h0,        32'h0,        0, 1, 5);
    vecs[11] = mk(0, 1, 0, 32'h20,        32'h20,       32'h0,        32'h0,        0, 0, 5);  // resume
    vecs[12] = mk(0, 0, 0, 32'h0,         32'h24,       32'h24,       32'h1000_0008, 1, 0, 6);
    vecs[13] = mk(1, 1, 0, 32'h43,        32'h40,       32'h0,        32'h0,        0, 0, 6);  // redirect over stall
    vecs[14] = mk(0, 0, 0, 32'h0,         32'h44,       32'h44,       32'h1000_0010, 1, 0, 7);
    vecs[15] = mk(0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 0, 7);  // halt dropped
    vecs[16] = mk(0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h4FFF_FFFF, 1, 0, 8);  // wrap
    vecs[17] = mk(0, 0, 0, 32'h0,         32'h4,        32'h4,        32'h1000_0000, 1, 0, 9);
    vecs[18] = mk(0, 1, 0, 32'h2C,        32'h2C,       32'h0,        32'h0,        0, 0, 9);
    vecs[19] = mk(0, 0, 0, 32'h0,         32'h30,       32'h30,       32'h1000_000B, 1, 0, 10);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt_req = 1'b0; redirect_pc = 32'h0;
    #3;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redir; halt_req = vecs[i].halt; redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].pc4, vecs[i].instr,
              vecs[i].valid, vecs[i].halted, vecs[i].cnt);
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0; halt_req = 1'b0; redirect_pc = 32'h0;

    // Async reset between edges while IF/ID is valid and PC=0x30
    @(posedge clk);
    #1;
    chk_all("pre_arst", 32'h34, 32'h34, 32'h1000_000C, 1'b1, 1'b0, 11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reboot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk_all("refetch", 32'h4, 32'h4, 32'h1000_0000, 1'b1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
